// File: rtl/head_gbus_wr_arb.sv
// head_gbus_wr_arb: buffers each core's fire-and-forget gbus writes in a
// private FIFO and round-robins them onto one registered valid/ready port.
module head_gbus_wr_arb #(
  parameter int CORE_NUM        = 4,
  parameter int GBUS_ADDR_WIDTH = 19,
  parameter int GBUS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0]   core_gbus_addr,
  input  logic [CORE_NUM-1:0]                   core_gbus_wen,
  input  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0]   core_gbus_wdata,
  input  logic                                  gbus_ready,
  output logic [GBUS_ADDR_WIDTH-1:0]            gbus_addr,
  output logic                                  gbus_wen,
  output logic [GBUS_DATA_WIDTH-1:0]            gbus_wdata,
  output logic [$clog2(CORE_NUM)-1:0]           gbus_src_id,
  input  logic                                  clear_err,
  output logic [CORE_NUM-1:0]                   ovf_err,
  output logic                                  busy
);

  localparam int SRC_W = $clog2(CORE_NUM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = GBUS_ADDR_WIDTH;
  localparam int DW    = GBUS_DATA_WIDTH;
  localparam int ENT_W = AW + DW;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q  [CORE_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q [CORE_NUM];
  logic [PTR_W-1:0] wptr_d [CORE_NUM];
  logic [PTR_W-1:0] rptr_q [CORE_NUM];
  logic [PTR_W-1:0] rptr_d [CORE_NUM];
  logic [CNT_W-1:0] cnt_q  [CORE_NUM];
  logic [CNT_W-1:0] cnt_d  [CORE_NUM];

  logic [CORE_NUM-1:0] req_s;
  logic [CORE_NUM-1:0] full_s;
  logic [CORE_NUM-1:0] pop_s;
  logic [CORE_NUM-1:0] push_s;
  logic [CORE_NUM-1:0] drop_s;

  // Arbiter
  logic             slot_free_s;
  logic             grant_vld_s;
  logic [SRC_W-1:0] grant_idx_s;
  logic [SRC_W-1:0] cand_s;
  logic [SRC_W-1:0] last_grant_q;
  logic [SRC_W-1:0] last_grant_d;
  logic [ENT_W-1:0] head_s;

  // Output register and error flags
  logic             wen_q,  wen_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SRC_W-1:0] src_q,  src_d;
  logic [CORE_NUM-1:0] ovf_q, ovf_d;

  // Per-core request and full flags derived from the occupancy counters
  always_comb begin
    req_s  = '0;
    full_s = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      req_s[i]  = (cnt_q[i] != '0);
      full_s[i] = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  assign slot_free_s = !wen_q || gbus_ready;

  // Round-robin search starting just after the last winner; only when the slot is free
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 1; k <= CORE_NUM; k++) begin
      cand_s = SRC_W'((int'(last_grant_q) + k) % CORE_NUM);
      if (slot_free_s && !grant_vld_s && req_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // FIFO push/pop decisions, drop detection and pointer/count next state
  always_comb begin
    pop_s  = '0;
    push_s = '0;
    drop_s = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      cnt_d[i]  = cnt_q[i];
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      pop_s[i]  = grant_vld_s && (grant_idx_s == SRC_W'(i));
      // A full FIFO still has room when it is being popped this cycle
      push_s[i] = core_gbus_wen[i] && (!full_s[i] || pop_s[i]);
      drop_s[i] = core_gbus_wen[i] && full_s[i] && !pop_s[i];
      if (push_s[i]) begin
        wptr_d[i] = wptr_q[i] + PTR_W'(1);
      end else begin
        wptr_d[i] = wptr_q[i];
      end
      if (pop_s[i]) begin
        rptr_d[i] = rptr_q[i] + PTR_W'(1);
      end else begin
        rptr_d[i] = rptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign head_s = mem_q[grant_idx_s][rptr_q[grant_idx_s]];

  // Output register load/hold, last-grant update and sticky overflow flags
  always_comb begin
    wen_d        = wen_q;
    addr_d       = addr_q;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (slot_free_s) begin
      if (grant_vld_s) begin
        wen_d        = 1'b1;
        addr_d       = head_s[ENT_W-1:DW];
        data_d       = head_s[DW-1:0];
        src_d        = grant_idx_s;
        last_grant_d = grant_idx_s;
      end else begin
        wen_d = 1'b0;
      end
    end else begin
      wen_d = wen_q;
    end
    // A new drop in the same cycle as a clear leaves the flag set
    if (clear_err) begin
      ovf_d = drop_s;
    end else begin
      ovf_d = ovf_q | drop_s;
    end
  end

  // FIFO payload storage; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_NUM; i++) begin
      if (push_s[i]) begin
        mem_q[i][wptr_q[i]] <= {core_gbus_addr[i*AW +: AW], core_gbus_wdata[i*DW +: DW]};
      end
    end
  end

  // FIFO pointers and counts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CORE_NUM; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CORE_NUM; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Output beat, arbitration history and error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      src_q        <= '0;
      ovf_q        <= '0;
      last_grant_q <= SRC_W'(CORE_NUM - 1);
    end else begin
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      src_q        <= src_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gbus_wen    = wen_q;
  assign gbus_addr   = addr_q;
  assign gbus_wdata  = data_q;
  assign gbus_src_id = src_q;
  assign ovf_err     = ovf_q;
  assign busy        = (|req_s) || wen_q;

endmodule

// File: tb/tb_head_gbus_wr_arb.sv
// Scoreboard bench for head_gbus_wr_arb: a queue-based reference model
// predicts beats; a negedge monitor compares DUT output against it.
module tb_head_gbus_wr_arb;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int D  = 4;

  typedef struct packed {
    logic [1:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [N*AW-1:0] core_gbus_addr = '0;
  logic [N-1:0]    core_gbus_wen = '0;
  logic [N*DW-1:0] core_gbus_wdata = '0;
  logic            gbus_ready = 1'b1;
  logic            clear_err = 1'b0;
  logic [AW-1:0]   gbus_addr;
  logic            gbus_wen;
  logic [DW-1:0]   gbus_wdata;
  logic [1:0]      gbus_src_id;
  logic [N-1:0]    ovf_err;
  logic            busy;

  head_gbus_wr_arb #(.CORE_NUM(N), .GBUS_ADDR_WIDTH(AW), .GBUS_DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .core_gbus_addr(core_gbus_addr), .core_gbus_wen(core_gbus_wen), .core_gbus_wdata(core_gbus_wdata),
    .gbus_ready(gbus_ready), .gbus_addr(gbus_addr), .gbus_wen(gbus_wen), .gbus_wdata(gbus_wdata),
    .gbus_src_id(gbus_src_id), .clear_err(clear_err), .ovf_err(ovf_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  beat_t       mq [N][$];
  beat_t       sb [$];
  beat_t       obs [$];
  logic        m_wen;
  beat_t       m_out;
  int          m_last;
  logic [N-1:0] m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    logic b;
    b = m_wen;
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    sb.delete();
    m_wen  = 1'b0;
    m_out  = '0;
    m_last = N - 1;
    m_ovf  = '0;
  endtask

  // one clock edge of the reference: grant from pre-edge occupancy, then accept pushes
  task automatic model_step();
    bit free;
    int win;
    logic [N-1:0] setv;
    beat_t e;
    free = !m_wen || gbus_ready;
    win  = -1;
    if (free) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (win < 0 && mq[idx].size() > 0) win = idx;
      end
    end
    if (win >= 0) begin
      e      = mq[win].pop_front();
      m_out  = e;
      m_last = win;
      m_wen  = 1'b1;
      sb.push_back(e);
    end else if (free) begin
      m_wen = 1'b0;
    end
    setv = '0;
    for (int i = 0; i < N; i++) begin
      if (core_gbus_wen[i]) begin
        if (mq[i].size() < D) begin
          e.s = 2'(i);
          e.a = core_gbus_addr[i*AW +: AW];
          e.d = core_gbus_wdata[i*DW +: DW];
          mq[i].push_back(e);
        end else begin
          setv[i] = 1'b1;
        end
      end
    end
    m_ovf = (clear_err ? '0 : m_ovf) | setv;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_gbus_wen[i] = 1'b1;
    core_gbus_addr[i*AW +: AW] = a;
    core_gbus_wdata[i*DW +: DW] = d;
  endtask

  // advance one cycle; strobes and clear are single-cycle
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    core_gbus_wen = '0;
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    core_gbus_wen = '0;
    #1;
    chk("rst_wen", gbus_wen, 1'b0);
    chk("rst_addr", gbus_addr, '0);
    chk("rst_data", gbus_wdata, '0);
    chk("rst_src", gbus_src_id, '0);
    chk("rst_ovf", ovf_err, '0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // monitor: per-cycle state against the model, and every transfer against the scoreboard
  initial begin
    beat_t ex;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("wen", gbus_wen, m_wen);
        chk("addr", gbus_addr, m_out.a);
        chk("data", gbus_wdata, m_out.d);
        chk("src", gbus_src_id, m_out.s);
        chk("ovf", ovf_err, m_ovf);
        chk("busy", busy, m_busy());
        if (gbus_wen && gbus_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got beat src %0d data %0h, expected none", gbus_src_id, gbus_wdata);
          end else begin
            ex = sb.pop_front();
            chk("beat_src", gbus_src_id, ex.s);
            chk("beat_addr", gbus_addr, ex.a);
            chk("beat_data", gbus_wdata, ex.d);
          end
          obs.push_back('{s: gbus_src_id, a: gbus_addr, d: gbus_wdata});
        end
      end
    end
  end

  initial begin
    int cnt;
    model_reset();
    #2;
    do_reset();
    gbus_ready = 1'b1;

    // single write latency from core 2
    repeat (5) step();
    set_wr(2, 19'h01234, 32'hDEADBEEF);
    step();
    chk("lat_t1_wen", gbus_wen, 1'b0);
    chk("lat_t1_busy", busy, 1'b1);
    step();
    chk("lat_t2_wen", gbus_wen, 1'b1);
    chk("lat_t2_src", gbus_src_id, 2'd2);
    chk("lat_t2_addr", gbus_addr, 19'h01234);
    chk("lat_t2_data", gbus_wdata, 32'hDEADBEEF);
    chk("lat_t2_busy", busy, 1'b1);
    step();
    chk("lat_t3_wen", gbus_wen, 1'b0);
    chk("lat_t3_busy", busy, 1'b0);

    // two simultaneous bursts from reset state
    do_reset();
    for (int b = 0; b < 2; b++) begin
      obs.delete();
      for (int i = 0; i < N; i++) set_wr(i, AW'($urandom), DW'(32'hA0 + i));
      step();
      repeat (8) step();
      chk("burst_cnt", obs.size(), N);
      for (int j = 0; j < N && j < obs.size(); j++) begin
        chk("burst_src", obs[j].s, j);
        chk("burst_data", obs[j].d, 32'hA0 + j);
      end
    end

    // round-robin fairness between cores 0 and 3
    obs.delete();
    for (int c = 0; c < 20; c++) begin
      set_wr(0, AW'($urandom), DW'($urandom));
      set_wr(3, AW'($urandom), DW'($urandom));
      step();
    end
    repeat (20) step();
    if (obs.size() >= 16) begin
      chk("rr_first", obs[0].s, 2'd0);
      for (int j = 1; j < 16; j++) chk("rr_alt", obs[j].s == obs[j-1].s, 1'b0);
    end else begin
      chk("rr_cnt", obs.size(), 16);
    end
    clear_err = 1'b1;
    step();

    // backpressure on a single beat from core 1
    obs.delete();
    gbus_ready = 1'b0;
    set_wr(1, 19'h5A5A5, 32'h1234_5678);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_wen", gbus_wen, 1'b1);
      chk("bp_addr", gbus_addr, 19'h5A5A5);
      chk("bp_data", gbus_wdata, 32'h1234_5678);
      chk("bp_src", gbus_src_id, 2'd1);
      if (k < 4) step();
    end
    gbus_ready = 1'b1;
    step();
    chk("bp_after_wen", gbus_wen, 1'b0);
    chk("bp_beats", obs.size(), 1);

    // overflow: 7 writes into a blocked port
    obs.delete();
    gbus_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      set_wr(1, AW'(k * 16), DW'(k));
      step();
    end
    step();
    chk("ovf_flag", ovf_err, 4'b0010);
    chk("ovf_out_data", gbus_wdata, 32'd1);
    gbus_ready = 1'b1;
    repeat (8) step();
    chk("ovf_beats", obs.size(), 5);
    for (int j = 0; j < 5 && j < obs.size(); j++) chk("ovf_order", obs[j].d, j + 1);
    chk("ovf_sticky", ovf_err, 4'b0010);
    clear_err = 1'b1;
    step();
    chk("ovf_cleared", ovf_err, 4'b0000);

    // reset with three entries queued and a beat pending
    gbus_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_wr(0, AW'($urandom), DW'(32'h100 + k));
      step();
    end
    chk("mid_wen", gbus_wen, 1'b1);
    do_reset();
    gbus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_idle", gbus_wen, 1'b0);
    end
    set_wr(0, 19'h00777, 32'hCAFE_0001);
    step();
    chk("post_rst_t1", gbus_wen, 1'b0);
    step();
    chk("post_rst_t2_wen", gbus_wen, 1'b1);
    chk("post_rst_t2_data", gbus_wdata, 32'hCAFE_0001);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 30) set_wr(i, AW'($urandom), DW'($urandom));
      end
      gbus_ready = ($urandom_range(0, 99) < 70);
      clear_err  = ($urandom_range(0, 99) < 3);
      step();
    end

    // drain, bounded
    gbus_ready = 1'b1;
    cnt = 0;
    while (m_busy() && cnt < 200) begin
      step();
      cnt++;
    end
    if (m_busy()) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", cnt);
    end
    step();
    chk("sb_drained", sb.size(), 0);
    chk("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
